// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one asynchronous 16-bit SRAM
// between a write stream (recorder) and a read stream (DSP/player).
// Owns every SRAM control pin and the DQ tristate. A one-cycle turnaround
// is inserted between a completed read and the next write.
// Optional build macro: SRAM_ARB_STATS_EN enables the conflict counter;
// without it o_conflict_cnt is tied to zero.
module sram_arbiter #(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output logic [15:0]       o_conflict_cnt
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STAT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_WR,
    S_RD,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_wr_q, last_wr_d;   // 1: last grant was write
  logic                prev_rd_q, prev_rd_d;   // 1: last completed access was a read
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                dq_oe_q, dq_oe_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                ce_n_q, ce_n_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_valid_q, rd_valid_d;
  logic                grant_wr, grant_rd;

  // Next-state and next-output logic; strobes are registered from the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_wr_d  = last_wr_q;
    prev_rd_d  = prev_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    dq_oe_d    = 1'b0;
    we_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    ce_n_d     = 1'b1;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_wr = i_wr_req && (!i_rd_req || !last_wr_q);
        grant_rd = i_rd_req && (!i_wr_req || last_wr_q);
        if (grant_wr) begin
          addr_d    = i_wr_addr;
          wdata_d   = i_wr_data;
          last_wr_d = 1'b1;
          cnt_d     = '0;
          if (prev_rd_q) begin
            state_d = S_TURN;
          end else begin
            state_d = S_WR;
            we_n_d  = 1'b0;
            ce_n_d  = 1'b0;
            dq_oe_d = 1'b1;
          end
        end else if (grant_rd) begin
          addr_d    = i_rd_addr;
          last_wr_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RD;
          oe_n_d    = 1'b0;
          ce_n_d    = 1'b0;
        end
      end

      S_TURN: begin
        state_d = S_WR;
        we_n_d  = 1'b0;
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end

      S_WR: begin
        dq_oe_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          wr_ack_d  = 1'b1;
          prev_rd_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          we_n_d = 1'b0;
          ce_n_d = 1'b0;
        end
      end

      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          rd_valid_d = 1'b1;
          rdata_d    = io_SRAM_DQ;
          prev_rd_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          oe_n_d = 1'b0;
          ce_n_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_wr_q  <= 1'b0;
      prev_rd_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      dq_oe_q    <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_wr_q  <= last_wr_d;
      prev_rd_q  <= prev_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      dq_oe_q    <= dq_oe_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      ce_n_q     <= ce_n_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_LB_N = ce_n_q;
  assign o_SRAM_UB_N = ce_n_q;
  assign o_wr_ack    = wr_ack_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rdata_q;

`ifdef SRAM_ARB_STATS_EN
  logic [STAT_W-1:0] conflict_q, conflict_d;

  // Count idle cycles where both streams compete, saturating at all-ones.
  always_comb begin
    conflict_d = conflict_q;
    if ((state_q == S_IDLE) && i_wr_req && i_rd_req && (conflict_q != {STAT_W{1'b1}})) begin
      conflict_d = conflict_q + STAT_W'(1);
    end
  end

  // Conflict counter register, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign o_conflict_cnt = conflict_q;
`else
  assign o_conflict_cnt = STAT_W'(0);
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: cycle-accurate vector table on an
// ACCESS_CYCLES=1 instance, plus directed sequences for reset/conflict,
// sustained alternation and reset in the middle of a 3-cycle write.
module tb_sram_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
`ifdef SRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance with ACCESS_CYCLES = 1 ----------------
  logic          rst_n, wr_req, rd_req, wr_ack, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr, sram_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          we_n, ce_n, oe_n, lb_n, ub_n;
  logic [15:0]   conflict_cnt;
  wire  [DW-1:0] dq;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n), .o_conflict_cnt(conflict_cnt)
  );

  // Small SRAM model covering the low 256 words.
  logic [DW-1:0] mem [256];
  assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : {DW{1'bz}};
  always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr[7:0]] <= dq;

  // ---------------- instance with ACCESS_CYCLES = 3 ----------------
  logic          rst3_n, wr3_req, rd3_req, wr3_ack, rd3_valid;
  logic [AW-1:0] wr3_addr, rd3_addr, sram3_addr;
  logic [DW-1:0] wr3_data, rd3_data;
  logic          we3_n, ce3_n, oe3_n, lb3_n, ub3_n;
  logic [15:0]   conflict3_cnt;
  wire  [DW-1:0] dq3;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst3_n),
    .i_wr_req(wr3_req), .i_wr_addr(wr3_addr), .i_wr_data(wr3_data), .o_wr_ack(wr3_ack),
    .i_rd_req(rd3_req), .i_rd_addr(rd3_addr), .o_rd_data(rd3_data), .o_rd_valid(rd3_valid),
    .o_SRAM_ADDR(sram3_addr), .io_SRAM_DQ(dq3),
    .o_SRAM_WE_N(we3_n), .o_SRAM_CE_N(ce3_n), .o_SRAM_OE_N(oe3_n),
    .o_SRAM_LB_N(lb3_n), .o_SRAM_UB_N(ub3_n), .o_conflict_cnt(conflict3_cnt)
  );

  // ---------------- helpers ----------------
  typedef struct {
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          ack, valid;
    logic [DW-1:0] rdata;
    logic          we_n, oe_n, ce_n;
    logic [AW-1:0] addr;
    logic [1:0]    dq_mode;   // 0 skip, 1 expect value, 2 expect released
    logic [DW-1:0] dq;
    logic [15:0]   cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  function automatic vec_t mk(logic w, logic r, logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic [AW-1:0] ra, logic ack, logic val, logic [DW-1:0] rdat,
                              logic wen, logic oen, logic cen, logic [AW-1:0] ad,
                              logic [1:0] dm, logic [DW-1:0] edq, logic [15:0] ec);
    vec_t v;
    v.wr_req = w;   v.rd_req = r;  v.wr_addr = wa; v.wr_data = wd; v.rd_addr = ra;
    v.ack = ack;    v.valid = val; v.rdata = rdat;
    v.we_n = wen;   v.oe_n = oen;  v.ce_n = cen;   v.addr = ad;
    v.dq_mode = dm; v.dq = edq;    v.cnt = ec;
    return v;
  endfunction

  function automatic logic released(logic [DW-1:0] v);
    return $isunknown(v) || (v == '0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  order [8];
    int          ngrant;
    int          cyc;
    logic        overlap;
    int          lowcnt;
    int          ack_at;
    logic        late_ack;

    //      w  r  wa       wd        ra       ack val rdata     we oe ce addr     dm dq        cnt
    vt[0]  = mk(1, 0, 20'h10, 16'hBEEF, 20'h0,  0, 0, 16'h0000, 0, 1, 0, 20'h10, 1, 16'hBEEF, 0);
    vt[1]  = mk(1, 0, 20'h10, 16'hBEEF, 20'h0,  1, 0, 16'h0000, 1, 1, 1, 20'h10, 1, 16'hBEEF, 0);
    vt[2]  = mk(1, 0, 20'h10, 16'hBEEF, 20'h0,  0, 0, 16'h0000, 1, 1, 1, 20'h10, 2, 16'h0000, 0);
    vt[3]  = mk(0, 1, 20'h10, 16'hBEEF, 20'h10, 0, 0, 16'h0000, 1, 0, 0, 20'h10, 1, 16'hBEEF, 0);
    vt[4]  = mk(0, 1, 20'h10, 16'hBEEF, 20'h10, 0, 1, 16'hBEEF, 1, 1, 1, 20'h10, 2, 16'h0000, 0);
    vt[5]  = mk(0, 1, 20'h10, 16'hBEEF, 20'h10, 0, 0, 16'hBEEF, 1, 1, 1, 20'h10, 2, 16'h0000, 0);
    vt[6]  = mk(1, 0, 20'h20, 16'h1234, 20'h10, 0, 0, 16'hBEEF, 1, 1, 1, 20'h20, 2, 16'h0000, 0);
    vt[7]  = mk(1, 0, 20'h20, 16'h1234, 20'h10, 0, 0, 16'hBEEF, 0, 1, 0, 20'h20, 1, 16'h1234, 0);
    vt[8]  = mk(1, 0, 20'h20, 16'h1234, 20'h10, 1, 0, 16'hBEEF, 1, 1, 1, 20'h20, 1, 16'h1234, 0);
    vt[9]  = mk(1, 0, 20'h20, 16'h1234, 20'h10, 0, 0, 16'hBEEF, 1, 1, 1, 20'h20, 2, 16'h0000, 0);
    vt[10] = mk(1, 1, 20'h30, 16'h5A5A, 20'h20, 0, 0, 16'hBEEF, 1, 0, 0, 20'h20, 1, 16'h1234, 1);
    vt[11] = mk(1, 1, 20'h30, 16'h5A5A, 20'h20, 0, 1, 16'h1234, 1, 1, 1, 20'h20, 2, 16'h0000, 1);
    vt[12] = mk(1, 1, 20'h30, 16'h5A5A, 20'h20, 0, 0, 16'h1234, 1, 1, 1, 20'h20, 2, 16'h0000, 1);
    vt[13] = mk(1, 0, 20'h30, 16'h5A5A, 20'h20, 0, 0, 16'h1234, 1, 1, 1, 20'h30, 2, 16'h0000, 1);
    vt[14] = mk(1, 0, 20'h30, 16'h5A5A, 20'h20, 0, 0, 16'h1234, 0, 1, 0, 20'h30, 1, 16'h5A5A, 1);
    vt[15] = mk(1, 0, 20'h30, 16'h5A5A, 20'h20, 1, 0, 16'h1234, 1, 1, 1, 20'h30, 1, 16'h5A5A, 1);
    vt[16] = mk(1, 0, 20'h30, 16'h5A5A, 20'h20, 0, 0, 16'h1234, 1, 1, 1, 20'h30, 2, 16'h0000, 1);
    vt[17] = mk(0, 0, 20'h30, 16'h5A5A, 20'h20, 0, 0, 16'h1234, 1, 1, 1, 20'h30, 2, 16'h0000, 1);

    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    rst3_n = 1'b0; wr3_req = 1'b0; rd3_req = 1'b0;
    wr3_addr = '0; wr3_data = '0; rd3_addr = '0;
    tick; tick; tick;

    // Reset state
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_lb_ub", {lb_n, ub_n}, 2'b11);
    chk("rst_addr", sram_addr, 0);
    chk("rst_ack_valid", {wr_ack, rd_valid}, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_dq_hiz", released(dq), 1);
    rst_n = 1'b1;
    rst3_n = 1'b1;

    // Vector table: inputs held across one edge, outputs compared after it
    for (int i = 0; i < NV; i++) begin
      wr_req = vt[i].wr_req; rd_req = vt[i].rd_req;
      wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data; rd_addr = vt[i].rd_addr;
      tick;
      chk($sformatf("v%0d_ack", i), wr_ack, vt[i].ack);
      chk($sformatf("v%0d_valid", i), rd_valid, vt[i].valid);
      chk($sformatf("v%0d_rdata", i), rd_data, vt[i].rdata);
      chk($sformatf("v%0d_we_n", i), we_n, vt[i].we_n);
      chk($sformatf("v%0d_oe_n", i), oe_n, vt[i].oe_n);
      chk($sformatf("v%0d_ce_lb_ub", i), {ce_n, lb_n, ub_n}, {3{vt[i].ce_n}});
      chk($sformatf("v%0d_addr", i), sram_addr, vt[i].addr);
      if (vt[i].dq_mode == 2'd1) chk($sformatf("v%0d_dq", i), dq, vt[i].dq);
      else if (vt[i].dq_mode == 2'd2) chk($sformatf("v%0d_dq_hiz", i), released(dq), 1);
      chk($sformatf("v%0d_cnt", i), conflict_cnt, STATS ? vt[i].cnt : 16'd0);
    end

    // Conflict right after reset goes to write first
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    tick; tick;
    chk("rst2_rdata", rd_data, 0);
    chk("rst2_cnt", conflict_cnt, 0);
    rst_n = 1'b1;
    wr_req = 1'b1; wr_addr = 20'h40; wr_data = 16'hCAFE;
    rd_req = 1'b1; rd_addr = 20'h10;
    tick;
    chk("conf_first_we_n", we_n, 0);
    chk("conf_first_oe_n", oe_n, 1);
    chk("conf_cnt", conflict_cnt, STATS ? 32'd1 : 32'd0);
    tick;
    chk("conf_wr_ack", wr_ack, 1);
    tick;
    wr_req = 1'b0;
    tick;
    chk("conf_rd_oe_n", oe_n, 0);
    tick;
    chk("conf_rd_valid", rd_valid, 1);
    chk("conf_rd_data", rd_data, 16'hBEEF);
    tick;
    rd_req = 1'b0;

    // Sustained dual requests: 8 grants alternating W,R with no strobe overlap
    wr_req = 1'b1; wr_addr = 20'h50; wr_data = 16'h0F0F;
    rd_req = 1'b1; rd_addr = 20'h10;
    ngrant = 0; cyc = 0; overlap = 1'b0;
    while (ngrant < 8 && cyc < 200) begin
      tick;
      cyc++;
      if (!we_n && !oe_n) overlap = 1'b1;
      if (wr_ack) begin order[ngrant] = "W"; ngrant++; end
      if (rd_valid) begin
        order[ngrant] = "R"; ngrant++;
        chk("alt_rd_data", rd_data, 16'hBEEF);
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("alt_grants_done", ngrant, 8);
    for (int i = 0; i < ngrant; i++)
      chk($sformatf("alt_order%0d", i), order[i], (i % 2 == 0) ? "W" : "R");
    chk("alt_no_overlap", overlap, 0);
    tick; tick;
    chk("alt_cnt", conflict_cnt, STATS ? 32'd9 : 32'd0);

    // ACCESS_CYCLES = 3: full write timing
    wr3_req = 1'b1; wr3_addr = 20'h7; wr3_data = 16'hA5C3;
    lowcnt = 0; ack_at = 0;
    for (int k = 1; k <= 10 && ack_at == 0; k++) begin
      tick;
      if (!we3_n) lowcnt++;
      if (k == 1) chk("ac3_dq", dq3, 16'hA5C3);
      if (wr3_ack) ack_at = k;
    end
    chk("ac3_we_low_cycles", lowcnt, 3);
    chk("ac3_ack_latency", ack_at, 4);
    tick;
    wr3_req = 1'b0;
    tick;

    // ACCESS_CYCLES = 3: reset during the second write cycle
    wr3_req = 1'b1; wr3_addr = 20'h8; wr3_data = 16'h3C5A;
    tick;
    chk("mid_wr1_we_n", we3_n, 0);
    tick;
    chk("mid_wr2_we_n", we3_n, 0);
    chk("mid_wr2_dq", dq3, 16'h3C5A);
    rst3_n = 1'b0; wr3_req = 1'b0;
    tick;
    chk("mid_rst_we_n", we3_n, 1);
    chk("mid_rst_ce_n", ce3_n, 1);
    chk("mid_rst_dq_hiz", released(dq3), 1);
    chk("mid_rst_ack", wr3_ack, 0);
    rst3_n = 1'b1;
    late_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (wr3_ack) late_ack = 1'b1;
    end
    chk("mid_rst_no_late_ack", late_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
